// File: rtl/row_pkg.sv
// Shared types and defaults for the row counter that feeds the 7-segment stage.
package row_pkg;

    // Frame-tracking FSM states. The encoding is fixed so the debug state output stays stable.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ROW  = 2'd1,
        DONE = 2'd2
    } state_t;

    // cnt_row_o width, matching the segment stage's cnt_row_i.
    localparam int CNT_W        = 10;
    // Largest count that still fits in three decimal digits.
    localparam int MAX_ROWS_DEF = 999;
    // Default pixels per row.
    localparam int COLS_DEF     = 640;

endpackage

// File: rtl/row_counter.sv
// Counts completed rows of a pixel stream, frame by frame.
// The FSM tracks the frame (IDLE -> ROW -> DONE -> IDLE).
// A column counter finds the row boundaries.
// A saturating row counter drives the display bus.
// Malformed rows and frames, and saturation, set a sticky error.
//
// Handshake: a pixel beat is accepted on a rising edge where pix_valid_i && pix_ready_o.
// pix_ready_o is registered. It is low only while the FSM sits in DONE, so the
// frame_done_o pulse and the ready gap always occur in the same cycle.
module row_counter #(
    parameter int COLS     = row_pkg::COLS_DEF,
    parameter int MAX_ROWS = row_pkg::MAX_ROWS_DEF,
    parameter int CNT_W    = row_pkg::CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pix_valid_i,
    output logic             pix_ready_o,
    input  logic             pix_sof_i,
    input  logic             pix_eol_i,
    input  logic             pix_eof_i,
    input  logic             clr_i,
    output logic [CNT_W-1:0] cnt_row_o,
    output logic             frame_done_o,
    output logic             err_o,
    output logic [1:0]       dbg_state_o
);
    import row_pkg::*;

    // COLS below 2 is illegal. Clamp the width so the counter stays at least 1 bit wide.
    localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);
    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_ROWS);

    state_t           state_q, state_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             ready_q, ready_d;
    logic             done_q, done_d;

    // Per-beat decode shared by all the registers below.
    logic             beat;
    logic             sof_beat;
    logic             active;
    logic [COL_W-1:0] pos;
    logic             at_last;
    logic             row_done;
    logic             row_bad;
    logic             restart;
    logic             sat;
    logic [CNT_W-1:0] cnt_base;

    // Classify the current beat.
    // A sof beat always sits at column 0 of a fresh frame.
    // Only beats inside a frame, or a sof beat, take part in counting.
    always_comb begin
        beat     = pix_valid_i && ready_q;
        sof_beat = beat && pix_sof_i;
        active   = beat && ((state_q == ROW) || pix_sof_i);
        pos      = sof_beat ? '0 : col_q;
        at_last  = (pos == LAST_COL);
        // eof always closes the row, even without eol.
        row_done = active && (pix_eol_i || pix_eof_i || at_last);
        // Three malformed cases:
        //  - short row: the row closes before its last column.
        //  - long row: the last column arrives without eol.
        //  - eof without eol.
        row_bad  = active && (((pix_eol_i || pix_eof_i) && !at_last) ||
                              (at_last && !pix_eol_i));
        restart  = sof_beat && (state_q == ROW);
        // A sof beat zeroes the count before the row it closes (if any) is added.
        cnt_base = sof_beat ? '0 : cnt_q;
        sat      = row_done && (cnt_base == MAX_CNT);
    end

    // FSM next state and the registered outputs derived from it. clr_i has top priority.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (sof_beat) begin
                    state_d = pix_eof_i ? DONE : ROW;
                end
            end
            ROW: begin
                if (beat && pix_eof_i) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (clr_i) begin
            state_d = IDLE;
        end
        ready_d = (state_d != DONE);
        done_d  = (state_d == DONE);
    end

    // Column, row-count and error next values.
    always_comb begin
        col_d = col_q;
        cnt_d = cnt_q;
        err_d = err_q;
        if (clr_i) begin
            col_d = '0;
            cnt_d = '0;
            err_d = 1'b0;
        end else begin
            if (active) begin
                col_d = row_done ? '0 : pos + COL_W'(1);
                cnt_d = (row_done && !sat) ? cnt_base + CNT_W'(1) : cnt_base;
            end
            err_d = err_q | row_bad | sat | restart;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Column counter: beats seen so far in the current row.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q <= '0;
        end else begin
            col_q <= col_d;
        end
    end

    // Saturating row counter that drives the display bus.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Sticky protocol and overflow error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    // Handshake ready and frame-done pulse.
    // Both are held low in reset; ready rises on the first edge after reset releases.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            ready_q <= ready_d;
            done_q  <= done_d;
        end
    end

    assign pix_ready_o  = ready_q;
    assign cnt_row_o    = cnt_q;
    assign frame_done_o = done_q;
    assign err_o        = err_q;
    assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_row_counter.sv
// Directed bench for row_counter.
// The DUT is built with COLS=4 and MAX_ROWS=5, so saturation is reachable quickly.
// Inputs change on the falling edge. Outputs are sampled on the falling edge after the
// rising edge that consumed a beat.
module tb_row_counter;

    localparam int CNT_W = 10;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ROW  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic             clk;
    logic             rst;
    logic             pix_valid_i;
    logic             pix_ready_o;
    logic             pix_sof_i;
    logic             pix_eol_i;
    logic             pix_eof_i;
    logic             clr_i;
    logic [CNT_W-1:0] cnt_row_o;
    logic             frame_done_o;
    logic             err_o;
    logic [1:0]       dbg_state_o;

    int n_vec;
    int n_bad;

    row_counter #(
        .COLS     (4),
        .MAX_ROWS (5),
        .CNT_W    (CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .pix_valid_i  (pix_valid_i),
        .pix_ready_o  (pix_ready_o),
        .pix_sof_i    (pix_sof_i),
        .pix_eol_i    (pix_eol_i),
        .pix_eof_i    (pix_eof_i),
        .clr_i        (clr_i),
        .cnt_row_o    (cnt_row_o),
        .frame_done_o (frame_done_o),
        .err_o        (err_o),
        .dbg_state_o  (dbg_state_o)
    );

    // Clock and reset.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compares one observed value against its expected value and counts the comparison.
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Checks all observable outputs at once.
    task automatic check_all(input string tag, input int cnt, input logic err,
                             input logic fd, input logic rdy, input logic [1:0] st);
        check({tag, ".cnt"},   32'(cnt_row_o),    32'(cnt));
        check({tag, ".err"},   32'(err_o),        32'(err));
        check({tag, ".done"},  32'(frame_done_o), 32'(fd));
        check({tag, ".ready"}, 32'(pix_ready_o),  32'(rdy));
        check({tag, ".state"}, 32'(dbg_state_o),  32'(st));
    endtask

    // Driver: presents one beat for one cycle, optionally with clr_i.
    // The task is entered and left on a falling edge.
    task automatic send(input logic sof, input logic eol, input logic eof, input logic clr = 1'b0);
        pix_valid_i = 1'b1;
        pix_sof_i   = sof;
        pix_eol_i   = eol;
        pix_eof_i   = eof;
        clr_i       = clr;
        @(negedge clk);
        pix_valid_i = 1'b0;
        pix_sof_i   = 1'b0;
        pix_eol_i   = 1'b0;
        pix_eof_i   = 1'b0;
        clr_i       = 1'b0;
    endtask

    // Driver: one well-formed 4-beat row with eol on the last beat.
    task automatic send_row(input logic first, input logic last);
        send(first, 1'b0, 1'b0);
        send(1'b0, 1'b0, 1'b0);
        send(1'b0, 1'b0, 1'b0);
        send(1'b0, 1'b1, last);
    endtask

    // Driver: clr_i alone for one cycle.
    task automatic do_clear();
        clr_i = 1'b1;
        @(negedge clk);
        clr_i = 1'b0;
    endtask

    initial begin
        n_vec       = 0;
        n_bad       = 0;
        rst         = 1'b1;
        pix_valid_i = 1'b0;
        pix_sof_i   = 1'b0;
        pix_eol_i   = 1'b0;
        pix_eof_i   = 1'b0;
        clr_i       = 1'b0;

        // Reset state, then ready rises one edge after release.
        repeat (2) @(negedge clk);
        check_all("reset", 0, 1'b0, 1'b0, 1'b0, S_IDLE);
        rst = 1'b0;
        check("rel.ready_still_low", 32'(pix_ready_o), 32'd0);
        @(negedge clk);
        check_all("rel", 0, 1'b0, 1'b0, 1'b1, S_IDLE);

        // Three clean rows; the count steps one cycle after each eol beat.
        send(1'b1, 1'b0, 1'b0);
        send(1'b0, 1'b0, 1'b0);
        send(1'b0, 1'b0, 1'b0);
        check_all("t1.pre_eol", 0, 1'b0, 1'b0, 1'b1, S_ROW);
        send(1'b0, 1'b1, 1'b0);
        check_all("t1.row1", 1, 1'b0, 1'b0, 1'b1, S_ROW);
        send_row(1'b0, 1'b0);
        check_all("t1.row2", 2, 1'b0, 1'b0, 1'b1, S_ROW);
        send_row(1'b0, 1'b1);
        check_all("t1.eof", 3, 1'b0, 1'b1, 1'b0, S_DONE);
        @(negedge clk);
        check_all("t1.after", 3, 1'b0, 1'b0, 1'b1, S_IDLE);
        send(1'b0, 1'b1, 1'b0);
        check_all("t1.idle_drop", 3, 1'b0, 1'b0, 1'b1, S_IDLE);

        // Short row: eol on beat 2. The row still counts, and err stays high until clr.
        send(1'b1, 1'b0, 1'b0);
        check("t2.sof_zero", 32'(cnt_row_o), 32'd0);
        send(1'b0, 1'b0, 1'b0);
        send(1'b0, 1'b0, 1'b0);
        send(1'b0, 1'b1, 1'b0);
        check_all("t2.row1", 1, 1'b0, 1'b0, 1'b1, S_ROW);
        send(1'b0, 1'b0, 1'b0);
        send(1'b0, 1'b1, 1'b0);
        check_all("t2.short", 2, 1'b1, 1'b0, 1'b1, S_ROW);
        send_row(1'b0, 1'b0);
        check_all("t2.sticky", 3, 1'b1, 1'b0, 1'b1, S_ROW);
        do_clear();
        check_all("t2.clr", 0, 1'b0, 1'b0, 1'b1, S_IDLE);

        // Saturation at MAX_ROWS=5 across a 7-row frame.
        for (int r = 1; r <= 7; r++) begin
            send_row(r == 1, r == 7);
            check($sformatf("t3.cnt%0d", r), 32'(cnt_row_o), (r <= 5) ? 32'(r) : 32'd5);
            check($sformatf("t3.err%0d", r), 32'(err_o), (r >= 6) ? 32'd1 : 32'd0);
        end
        check("t3.done", 32'(frame_done_o), 32'd1);
        @(negedge clk);
        do_clear();

        // A sof beat mid-frame restarts the count and flags an error.
        send_row(1'b1, 1'b0);
        send_row(1'b0, 1'b0);
        check_all("t4.two", 2, 1'b0, 1'b0, 1'b1, S_ROW);
        send(1'b1, 1'b0, 1'b0);
        check_all("t4.restart", 0, 1'b1, 1'b0, 1'b1, S_ROW);
        send(1'b0, 1'b0, 1'b0);
        send(1'b0, 1'b0, 1'b0);
        send(1'b0, 1'b1, 1'b0);
        check_all("t4.next", 1, 1'b1, 1'b0, 1'b1, S_ROW);
        do_clear();

        // clr_i wins over an eol beat in the same cycle.
        send(1'b1, 1'b0, 1'b0);
        send(1'b0, 1'b0, 1'b0);
        send(1'b0, 1'b1, 1'b0);
        check_all("t5.short", 1, 1'b1, 1'b0, 1'b1, S_ROW);
        send(1'b0, 1'b0, 1'b0);
        send(1'b0, 1'b0, 1'b0);
        send(1'b0, 1'b0, 1'b0);
        send(1'b0, 1'b1, 1'b0, 1'b1);
        check_all("t5.clr_eol", 0, 1'b0, 1'b0, 1'b1, S_IDLE);
        send(1'b0, 1'b1, 1'b0);
        check_all("t5.drop", 0, 1'b0, 1'b0, 1'b1, S_IDLE);

        // Asynchronous reset in the middle of a row.
        send(1'b1, 1'b0, 1'b0);
        send(1'b0, 1'b1, 1'b0);
        send(1'b0, 1'b0, 1'b0);
        check_all("t6.pre", 1, 1'b1, 1'b0, 1'b1, S_ROW);
        #2;
        rst = 1'b1;
        #1;
        check_all("t6.async", 0, 1'b0, 1'b0, 1'b0, S_IDLE);
        @(negedge clk);
        rst = 1'b0;
        check("t6.rel_low", 32'(pix_ready_o), 32'd0);
        @(negedge clk);
        check("t6.rel_high", 32'(pix_ready_o), 32'd1);
        send(1'b0, 1'b1, 1'b0);
        send(1'b0, 1'b0, 1'b1);
        send(1'b0, 1'b0, 1'b0);
        check_all("t6.idle_beats", 0, 1'b0, 1'b0, 1'b1, S_IDLE);

        // sof+eol+eof on a single beat: a 1-row frame, short, so err is set.
        send(1'b1, 1'b1, 1'b1);
        check_all("b1.one_beat", 1, 1'b1, 1'b1, 1'b0, S_DONE);
        @(negedge clk);
        check_all("b1.after", 1, 1'b1, 1'b0, 1'b1, S_IDLE);
        do_clear();

        // Long row: the 4th beat without eol closes the row with an error.
        send(1'b1, 1'b0, 1'b0);
        send(1'b0, 1'b0, 1'b0);
        send(1'b0, 1'b0, 1'b0);
        send(1'b0, 1'b0, 1'b0);
        check_all("b2.long", 1, 1'b1, 1'b0, 1'b1, S_ROW);
        send_row(1'b0, 1'b0);
        check("b2.next_row", 32'(cnt_row_o), 32'd2);
        do_clear();

        // eof without eol at the last column still completes the frame, with an error.
        send_row(1'b1, 1'b0);
        send(1'b0, 1'b0, 1'b0);
        send(1'b0, 1'b0, 1'b0);
        send(1'b0, 1'b0, 1'b0);
        send(1'b0, 1'b0, 1'b1);
        check_all("b3.eof_no_eol", 2, 1'b1, 1'b1, 1'b0, S_DONE);
        @(negedge clk);
        check_all("b3.hold", 2, 1'b1, 1'b0, 1'b1, S_IDLE);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
